scarv_mem_axi_arbiter: RTL

//  Merges CHANNELS SRAM-style memory ports (cen/wen/ben/stall/error, as used by the COP) onto one AXI4-lite master.

---
 rtl/scarv_mem_axi_arbiter_pkg.sv | 10 +
 rtl/scarv_rr_arbiter.sv | 30 +++
 rtl/scarv_mem_axi_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/scarv_mem_axi_arbiter_pkg.sv
// scarv_mem_axi_arbiter_pkg: FSM state encodings and AXI response codes shared by the arbiter
package scarv_mem_axi_arbiter_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WADDR, ST_WRESP, ST_RADDR, ST_RDATA, ST_DONE} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic resp_is_err(input logic [1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR) || ((r != RESP_OKAY) && r[1]);
  endfunction
endpackage

// File: rtl/scarv_rr_arbiter.sv
// scarv_rr_arbiter: N-way round-robin grant (one-hot + index) starting after the last-granted channel
//   req_i  : request vector
//   last_i : index of the previously granted channel
//   gnt_o  : one-hot grant, zero when no request
//   idx_o  : index of the granted channel (last_i when no request)
module scarv_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  int c;
  // Walk from lowest priority (last_i itself) to highest (last_i+1); the final hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = last_i;
    c = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(last_i) + k) % N;
      if (req_i[c]) begin
        gnt_o = '0;
        gnt_o[c] = 1'b1;
        idx_o = IW'(c);
      end
    end
  end
endmodule

// File: rtl/scarv_mem_axi_arbiter.sv
// scarv_mem_axi_arbiter: round-robin merge of CHANNELS SRAM-style requesters onto one AXI4-lite master
//   g_clk/g_resetn          : clock, asynchronous active-low reset
//   req_cen/wen/addr/wdata/ben : per-channel requests, held until stall drops
//   req_stall/req_error     : per-channel stall and completion-cycle error
//   req_rdata               : shared read data, valid in the completion cycle
//   axi_*                   : AXI4-lite master, one outstanding transaction
//   Optional macro SCARV_MEM_ARB_ERROR_EN adds axi_bresp/axi_rresp and drives req_error.
module scarv_mem_axi_arbiter
  import scarv_mem_axi_arbiter_pkg::*;
#(
  parameter int         CHANNELS = 2,
  parameter int         AW       = 32,
  parameter int         DW       = 32,
  parameter logic [2:0] AXI_PROT = 3'b000
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic [CHANNELS-1:0]      req_cen,
  input  logic [CHANNELS-1:0]      req_wen,
  input  logic [CHANNELS*AW-1:0]   req_addr,
  input  logic [CHANNELS*DW-1:0]   req_wdata,
  input  logic [CHANNELS*DW/8-1:0] req_ben,
  output logic [CHANNELS-1:0]      req_stall,
  output logic [CHANNELS-1:0]      req_error,
  output logic [DW-1:0]            req_rdata,
  output logic                     axi_awvalid,
  input  logic                     axi_awready,
  output logic [AW-1:0]            axi_awaddr,
  output logic [2:0]               axi_awprot,
  output logic                     axi_wvalid,
  input  logic                     axi_wready,
  output logic [DW-1:0]            axi_wdata,
  output logic [DW/8-1:0]          axi_wstrb,
  input  logic                     axi_bvalid,
  output logic                     axi_bready,
`ifdef SCARV_MEM_ARB_ERROR_EN
  input  logic [1:0]               axi_bresp,
  input  logic [1:0]               axi_rresp,
`endif
  output logic                     axi_arvalid,
  input  logic                     axi_arready,
  output logic [AW-1:0]            axi_araddr,
  output logic [2:0]               axi_arprot,
  input  logic                     axi_rvalid,
  output logic                     axi_rready,
  input  logic [DW-1:0]            axi_rdata
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW = DW / 8;
  state_e                state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d, rr_q, rr_d, gidx;
  logic [CHANNELS-1:0]   gnt_q, gnt_d, gnt;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d, rdata_q, rdata_d;
  logic [BW-1:0]         ben_q, ben_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  done;
  scarv_rr_arbiter #(.N(CHANNELS), .IW(IW)) u_rr (
    .req_i  (req_cen),
    .last_i (rr_q),
    .gnt_o  (gnt),
    .idx_o  (gidx)
  );
  assign done        = state_q == ST_DONE;
  assign req_stall   = req_cen & ~(done ? gnt_q : '0);
  assign req_rdata   = rdata_q;
  assign axi_awvalid = (state_q == ST_WADDR) & ~aw_done_q;
  assign axi_wvalid  = (state_q == ST_WADDR) & ~w_done_q;
  assign axi_awaddr  = addr_q & ~AW'(BW - 1);
  assign axi_araddr  = addr_q & ~AW'(BW - 1);
  assign axi_awprot  = AXI_PROT;
  assign axi_arprot  = AXI_PROT;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = ben_q;
  assign axi_bready  = state_q == ST_WRESP;
  assign axi_arvalid = state_q == ST_RADDR;
  assign axi_rready  = state_q == ST_RDATA;
`ifdef SCARV_MEM_ARB_ERROR_EN
  logic err_q, err_d;
  assign req_error = done ? (gnt_q & {CHANNELS{err_q}}) : '0;
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) err_q <= 1'b0;
    else err_q <= err_d;
  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE) err_d = 1'b0;
    if (state_q == ST_WRESP && axi_bvalid) err_d = resp_is_err(axi_bresp);
    if (state_q == ST_RDATA && axi_rvalid) err_d = resp_is_err(axi_rresp);
  end
`else
  assign req_error = '0;
`endif
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gnt_q     <= '0;
      rr_q      <= IW'(CHANNELS - 1);
      addr_q    <= '0;
      wdata_q   <= '0;
      ben_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ben_q     <= ben_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ben_d     = ben_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: if (|req_cen) begin
        grant_d   = gidx;
        gnt_d     = gnt;
        addr_d    = req_addr[gidx*AW +: AW];
        wdata_d   = req_wdata[gidx*DW +: DW];
        ben_d     = req_ben[gidx*BW +: BW];
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = req_wen[gidx] ? ST_WADDR : ST_RADDR;
      end
      // AW and W handshake independently; leave once both have completed.
      ST_WADDR: begin
        aw_done_d = aw_done_q | axi_awready;
        w_done_d  = w_done_q | axi_wready;
        state_d   = (aw_done_d & w_done_d) ? ST_WRESP : ST_WADDR;
      end
      ST_WRESP: state_d = axi_bvalid ? ST_DONE : ST_WRESP;
      ST_RADDR: state_d = axi_arready ? ST_RDATA : ST_RADDR;
      ST_RDATA: if (axi_rvalid) begin
        rdata_d = axi_rdata;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        rr_d    = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule
